// File: rtl/tdm_transmit.sv
// tdm_transmit -- TDM slave transmitter (microphone-array emulator).
//
// Runs on the system clock, oversamples the externally driven bit clock and
// frame sync, and serializes one SAMPLE_W-bit sample per 32-bit slot onto
// sd_out, MSB first. The unused tail of each slot is driven 0. The next
// frame's samples are taken through a one-frame-deep valid/ready buffer.
//
// Ports:
//   clk_in           system clock
//   rst_in           synchronous active-high reset
//   sck_in           TDM bit clock (asynchronous to clk_in)
//   ws_in            frame-sync pulse, one sck wide, sampled on sck rise
//   samples_in       next frame's samples, index = slot
//   valid_in         samples_in valid
//   ready_out        pending buffer empty (handshake on valid_in && ready_out)
//   sd_out           serial data (registered)
//   sd_oe_out        high while slot bits are driven (registered)
//   frame_start_out  one-cycle pulse per frame edge
//   underrun_out     one-cycle pulse when a frame edge finds no pending data
//   resync_out       one-cycle pulse when a frame edge cuts a frame short
//
// Build option:
//   TDM_TX_HOLD_LAST_EN  when defined, an underrun retransmits the previous
//                        frame instead of zeros.
module tdm_transmit #(
   parameter int SLOTS    = 2,
   parameter int SAMPLE_W = 24
) (
   input  logic                           clk_in,
   input  logic                           rst_in,
   input  logic                           sck_in,
   input  logic                           ws_in,
   input  logic [SLOTS-1:0][SAMPLE_W-1:0] samples_in,
   input  logic                           valid_in,
   output logic                           ready_out,
   output logic                           sd_out,
   output logic                           sd_oe_out,
   output logic                           frame_start_out,
   output logic                           underrun_out,
   output logic                           resync_out
);

   localparam int FRAME_BITS = SLOTS * 32;
   localparam int CW         = $clog2(FRAME_BITS) + 1;
   localparam logic [CW-1:0] LAST = CW'(FRAME_BITS);

   typedef enum logic {IDLE, SHIFT} state_t;

   state_t                         state, state_n;
   logic [CW-1:0]                  bidx, bidx_n;
   logic [SLOTS-1:0][SAMPLE_W-1:0] pend, pend_n;
   logic [SLOTS-1:0][SAMPLE_W-1:0] shift, shift_n;
   logic                           pend_full, pend_full_n;
   logic                           sd_n, oe_n, fs_n, ur_n, rs_n;

   logic sck_m, sck_s, sck_d;
   logic ws_m, ws_s;
   logic sck_rise, sck_fall, frame_edge;
   logic bit_val;
   logic [4:0]    pos;
   logic [CW-6:0] slot;

   // Two-flop synchronizers plus an sck edge register. All reset to 0 so a
   // reset never manufactures an sck edge.
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         sck_m <= 1'b0;
         sck_s <= 1'b0;
         sck_d <= 1'b0;
         ws_m  <= 1'b0;
         ws_s  <= 1'b0;
      end else begin
         sck_m <= sck_in;
         sck_s <= sck_m;
         sck_d <= sck_s;
         ws_m  <= ws_in;
         ws_s  <= ws_m;
      end
   end

   assign sck_rise   = sck_s & ~sck_d;
   assign sck_fall   = ~sck_s & sck_d;
   assign frame_edge = sck_rise & ws_s;
   assign ready_out  = ~pend_full;

   // Bit index splits into slot (upper bits) and position within the slot.
   assign pos  = bidx[4:0];
   assign slot = bidx[CW-1:5];

   // Current serial bit; positions at or beyond SAMPLE_W find no match and
   // stay 0, which pads the slot.
   always_comb begin
      bit_val = 1'b0;
      for (int s = 0; s < SLOTS; s++)
         for (int p = 0; p < SAMPLE_W; p++)
            if (slot == (CW-5)'(s) && pos == 5'(SAMPLE_W-1-p))
               bit_val = shift[s][p];
   end

   always_comb begin
      state_n     = state;
      bidx_n      = bidx;
      pend_n      = pend;
      pend_full_n = pend_full;
      shift_n     = shift;
      sd_n        = sd_out;
      oe_n        = sd_oe_out;
      fs_n        = 1'b0;
      ur_n        = 1'b0;
      rs_n        = 1'b0;

      // Handshake only happens while the buffer is empty. A frame edge in the
      // same cycle sees the old (empty) flag, so it underruns and the new
      // data stays pending for the following frame.
      if (valid_in && !pend_full) begin
         pend_n      = samples_in;
         pend_full_n = 1'b1;
      end

      if (frame_edge) begin
         fs_n    = 1'b1;
         state_n = SHIFT;
         bidx_n  = '0;
         if (state == SHIFT && bidx != LAST)
            rs_n = 1'b1;
         if (pend_full) begin
            shift_n     = pend;
            pend_full_n = 1'b0;
         end else begin
            ur_n = 1'b1;
`ifdef TDM_TX_HOLD_LAST_EN
            shift_n = shift;
`else
            shift_n = '0;
`endif
         end
      end else if (sck_fall && state == SHIFT) begin
         if (bidx == LAST) begin
            state_n = IDLE;
            sd_n    = 1'b0;
            oe_n    = 1'b0;
         end else begin
            sd_n   = bit_val;
            oe_n   = 1'b1;
            bidx_n = bidx + 1'b1;
         end
      end
   end

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         state           <= IDLE;
         bidx            <= '0;
         pend            <= '0;
         pend_full       <= 1'b0;
         shift           <= '0;
         sd_out          <= 1'b0;
         sd_oe_out       <= 1'b0;
         frame_start_out <= 1'b0;
         underrun_out    <= 1'b0;
         resync_out      <= 1'b0;
      end else begin
         state           <= state_n;
         bidx            <= bidx_n;
         pend            <= pend_n;
         pend_full       <= pend_full_n;
         shift           <= shift_n;
         sd_out          <= sd_n;
         sd_oe_out       <= oe_n;
         frame_start_out <= fs_n;
         underrun_out    <= ur_n;
         resync_out      <= rs_n;
      end
   end

endmodule

// File: tb/tb_tdm_transmit.sv
// Bench for tdm_transmit: directed frames with hand-computed slot contents
// plus a frame-level model checked against the DUT every clock.
module tb_tdm_transmit;
   localparam int SLOTS = 2;
   localparam int W     = 24;
   localparam int H     = 8;     // clk cycles per sck half period
   localparam int FB    = SLOTS * 32;

   logic clk_in = 1'b0;
   logic rst_in, sck_in, ws_in, valid_in;
   logic ready_out, sd_out, sd_oe_out, frame_start_out, underrun_out, resync_out;
   logic [SLOTS-1:0][W-1:0] samples_in;

   int n_total = 0;
   int n_bad   = 0;
   int cnt_fs  = 0;
   int cnt_ur  = 0;
   int cnt_rs  = 0;
   logic [63:0] rx, rxoe;

   tdm_transmit #(.SLOTS(SLOTS), .SAMPLE_W(W)) dut (
      .clk_in          (clk_in),
      .rst_in          (rst_in),
      .sck_in          (sck_in),
      .ws_in           (ws_in),
      .samples_in      (samples_in),
      .valid_in        (valid_in),
      .ready_out       (ready_out),
      .sd_out          (sd_out),
      .sd_oe_out       (sd_oe_out),
      .frame_start_out (frame_start_out),
      .underrun_out    (underrun_out),
      .resync_out      (resync_out)
   );

   always #5 clk_in = ~clk_in;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Frame-level model: a raw sck/ws change seen at a negedge takes effect
   // three clocks later; a handshake seen at a negedge lands on the next edge.
   initial begin : model
      logic [3:0] h_sck, h_ws;
      logic rst_q, hs_q, m_on, pfull, act, sd, oe, fs, ur, rs;
      int b;
      logic [W-1:0] cur [SLOTS];
      logic [W-1:0] pnd [SLOTS];
      logic [SLOTS-1:0][W-1:0] hs_data;
      h_sck = '0; h_ws = '0; rst_q = 1'b0; hs_q = 1'b0; m_on = 1'b0;
      pfull = 1'b0; act = 1'b0; sd = 1'b0; oe = 1'b0; b = 0; hs_data = '0;
      for (int s = 0; s < SLOTS; s++) begin cur[s] = '0; pnd[s] = '0; end
      forever begin
         @(negedge clk_in);
         fs = 1'b0; ur = 1'b0; rs = 1'b0;
         if (rst_q) begin
            m_on = 1'b1; pfull = 1'b0; act = 1'b0; b = 0; sd = 1'b0; oe = 1'b0;
            h_sck = '0; h_ws = '0;
            for (int s = 0; s < SLOTS; s++) cur[s] = '0;
         end else begin
            if (h_sck[2] && !h_sck[3] && h_ws[2]) begin
               fs = 1'b1;
               if (act && b < FB) rs = 1'b1;
               if (pfull) begin
                  for (int s = 0; s < SLOTS; s++) cur[s] = pnd[s];
                  pfull = 1'b0;
               end else begin
                  ur = 1'b1;
`ifndef TDM_TX_HOLD_LAST_EN
                  for (int s = 0; s < SLOTS; s++) cur[s] = '0;
`endif
               end
               act = 1'b1;
               b = 0;
            end
            if (!h_sck[2] && h_sck[3] && act) begin
               if (b == FB) begin
                  act = 1'b0; sd = 1'b0; oe = 1'b0;
               end else begin
                  sd = 1'b0;
                  if (b % 32 < W) sd = cur[b / 32][W - 1 - (b % 32)];
                  oe = 1'b1;
                  b++;
               end
            end
            if (hs_q) begin
               for (int s = 0; s < SLOTS; s++) pnd[s] = hs_data[s];
               pfull = 1'b1;
            end
         end
         if (m_on) begin
            check("cycle{sd,oe,fs,ur,rs,rdy}",
                  {26'b0, sd_out, sd_oe_out, frame_start_out, underrun_out, resync_out, ready_out},
                  {26'b0, sd, oe, fs, ur, rs, ~pfull});
            if (frame_start_out === 1'b1) cnt_fs++;
            if (underrun_out === 1'b1) cnt_ur++;
            if (resync_out === 1'b1) cnt_rs++;
         end
         hs_q    = valid_in && !pfull && !rst_in;
         hs_data = samples_in;
         rst_q   = rst_in;
         h_sck   = {h_sck[2:0], sck_in};
         h_ws    = {h_ws[2:0], ws_in};
      end
   end

   // One sck period: fall (ws set), low half, sample line, rise, high half.
   task automatic sck_cycle(input logic ws, output logic sd, output logic oe);
      ws_in = ws;
      sck_in = 1'b0;
      repeat (H) begin @(posedge clk_in); #1; end
      sd = sd_out;
      oe = sd_oe_out;
      sck_in = 1'b1;
      repeat (H) begin @(posedge clk_in); #1; end
   endtask

   // 64 bit periods after a frame edge; the last may carry the next ws.
   task automatic run_frame(input logic ws_last);
      logic sd, oe;
      for (int i = 0; i < FB; i++) begin
         sck_cycle((i == FB - 1) ? ws_last : 1'b0, sd, oe);
         rx[63 - i]   = sd;
         rxoe[63 - i] = oe;
      end
   endtask

   task automatic edge_only();
      logic sd, oe;
      sck_cycle(1'b1, sd, oe);
   endtask

   task automatic idle_cycle();
      logic sd, oe;
      sck_cycle(1'b0, sd, oe);
   endtask

   task automatic load(input logic [W-1:0] s0, input logic [W-1:0] s1);
      samples_in[0] = s0;
      samples_in[1] = s1;
      valid_in = 1'b1;
      @(posedge clk_in); #1;
      valid_in = 1'b0;
   endtask

   task automatic check_frame(input string name, input logic [W-1:0] s0, input logic [W-1:0] s1);
      check({name, ".slot0"}, {8'b0, rx[63:40]}, {8'b0, s0});
      check({name, ".slot1"}, {8'b0, rx[31:8]}, {8'b0, s1});
      check({name, ".pad"}, {16'b0, rx[39:32], rx[7:0]}, 32'h0);
      check({name, ".oe_hi"}, {31'b0, &rxoe}, 32'h1);
   endtask

   initial begin : stim
      int fs0, ur0, rs0;
      rst_in = 1'b1; sck_in = 1'b0; ws_in = 1'b0; valid_in = 1'b0; samples_in = '0;
      rx = '0; rxoe = '0;
      repeat (4) @(posedge clk_in);
      #1;
      rst_in = 1'b0;
      check("reset{sd,oe,fs,ur,rs,rdy}",
            {26'b0, sd_out, sd_oe_out, frame_start_out, underrun_out, resync_out, ready_out},
            32'h1);

      // Basic frame
      load(24'hABCDEF, 24'h123456);
      check("ready_after_load", {31'b0, ready_out}, 32'h0);
      fs0 = cnt_fs; ur0 = cnt_ur;
      edge_only();
      run_frame(1'b0);
      check_frame("basic", 24'hABCDEF, 24'h123456);
      check("basic.fs_pulses", fs0 == cnt_fs - 1 ? 32'h1 : 32'h0, 32'h1);
      check("basic.ur_pulses", 32'(cnt_ur - ur0), 32'h0);

      // Underrun
      ur0 = cnt_ur;
      idle_cycle();
      edge_only();
      run_frame(1'b0);
`ifdef TDM_TX_HOLD_LAST_EN
      check_frame("underrun", 24'hABCDEF, 24'h123456);
`else
      check_frame("underrun", 24'h000000, 24'h000000);
`endif
      check("underrun.ur_pulses", 32'(cnt_ur - ur0), 32'h1);

`ifdef TDM_TX_HOLD_LAST_EN
      // Held frame repeats across consecutive underruns
      load(24'h00F00F, 24'h00F00F);
      idle_cycle();
      edge_only();
      ur0 = cnt_ur;
      run_frame(1'b1);
      check_frame("hold0", 24'h00F00F, 24'h00F00F);
      run_frame(1'b1);
      check_frame("hold1", 24'h00F00F, 24'h00F00F);
      run_frame(1'b1);
      check_frame("hold2", 24'h00F00F, 24'h00F00F);
      run_frame(1'b0);
      check_frame("hold3", 24'h00F00F, 24'h00F00F);
      check("hold.ur_pulses", 32'(cnt_ur - ur0), 32'h3);
`endif

      // valid_in held high across two sample sets
      samples_in[0] = 24'h111111; samples_in[1] = 24'h222222;
      valid_in = 1'b1;
      @(posedge clk_in); #1;
      samples_in[0] = 24'h333333; samples_in[1] = 24'h444444;
      check("held_valid.ready_low", {31'b0, ready_out}, 32'h0);
      fork
         begin : drop_valid
            for (int k = 0; k < 5000; k++) begin
               @(negedge clk_in);
               if (ready_out && valid_in) begin
                  @(posedge clk_in); #1;
                  valid_in = 1'b0;
                  break;
               end
            end
         end
      join_none
      ur0 = cnt_ur; rs0 = cnt_rs;
      idle_cycle();
      edge_only();
      run_frame(1'b1);
      check_frame("held_valid.A", 24'h111111, 24'h222222);
      run_frame(1'b0);
      check_frame("held_valid.B", 24'h333333, 24'h444444);
      check("held_valid.ur_pulses", 32'(cnt_ur - ur0), 32'h0);
      check("held_valid.rs_pulses", 32'(cnt_rs - rs0), 32'h0);
      valid_in = 1'b0;

      // Early frame edge after 40 bits
      load(24'hABC123, 24'hDEF456);
      fs0 = cnt_fs; rs0 = cnt_rs;
      idle_cycle();
      edge_only();
      for (int i = 0; i < 39; i++) idle_cycle();
      load(24'hFEDCBA, 24'h987654);
      edge_only();
      run_frame(1'b0);
      check_frame("resync", 24'hFEDCBA, 24'h987654);
      check("resync.rs_pulses", 32'(cnt_rs - rs0), 32'h1);
      check("resync.fs_pulses", 32'(cnt_fs - fs0), 32'h2);

      // Reset at bit 30 with data pending
      load(24'h13579B, 24'h2468AC);
      idle_cycle();
      edge_only();
      for (int i = 0; i < 30; i++) idle_cycle();
      load(24'h0A0A0A, 24'h0B0B0B);
      check("midrst.ready_before", {31'b0, ready_out}, 32'h0);
      ws_in = 1'b0;
      sck_in = 1'b0;
      repeat (5) begin @(posedge clk_in); #1; end
      rst_in = 1'b1;
      @(posedge clk_in); #1;
      check("midrst.{sd,oe,rdy}", {29'b0, sd_out, sd_oe_out, ready_out}, 32'h1);
      rst_in = 1'b0;
      repeat (H) begin @(posedge clk_in); #1; end
      sck_in = 1'b1;
      repeat (H) begin @(posedge clk_in); #1; end
      ur0 = cnt_ur;
      edge_only();
      run_frame(1'b0);
      check_frame("after_rst", 24'h000000, 24'h000000);
      check("after_rst.ur_pulses", 32'(cnt_ur - ur0), 32'h1);

      idle_cycle();
      repeat (8) @(posedge clk_in);
      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule

// File: doc/tdm_transmit.md
# tdm_transmit

Synthesizable TDM slave transmitter: the microphone-array side of the TDM link our `tdm_receive` consumes. It runs on the 100 MHz system clock, samples the externally driven `sck_in`/`ws_in`, and serializes one 24-bit sample per slot onto `sd_out`. It acts as a mic-array emulator for hardware loopback (FPGA pins to PMOD) and as the stimulus source in receiver benches. Samples arrive through a one-frame-deep valid/ready buffer.

## Interface
- `SLOTS`, default 2: slots per frame; frame length is SLOTS*32 sck cycles.
- `SAMPLE_W`, default 24: data bits per slot, MSB first; the remaining 32-SAMPLE_W bits of each slot are driven 0.
- `clk_in` input 1: system clock (100 MHz).
- `rst_in` input 1: synchronous, active-high reset.
- `sck_in` input 1: TDM bit clock, asynchronous to `clk_in`.
- `ws_in` input 1: frame-sync pulse, one sck wide, sampled on sck rising edges.
- `samples_in` input [SLOTS] x SAMPLE_W: next frame's samples; index = slot.
- `valid_in` input 1: `samples_in` valid.
- `ready_out` output 1: pending buffer empty; handshake when `valid_in && ready_out`.
- `sd_out` output 1: serial data.
- `sd_oe_out` output 1: high while slot bits are driven (tri-state enable for the PMOD pin).
- `frame_start_out` output 1: one-cycle pulse on each frame edge.
- `underrun_out` output 1: one-cycle pulse when a frame edge finds the pending buffer empty.
- `resync_out` output 1: one-cycle pulse when a frame edge arrives before the current frame completes.

## Operation
- Input conditioning: `sck_in` and `ws_in` each pass through 2-flop synchronizers, then an edge register. Synchronizers reset to 0, so reset produces no spurious edges.
- sck rise = synchronized sck goes 0 to 1. sck fall = 1 to 0.
- Frame edge = an sck rise where synchronized `ws_in` is 1.
- Pending buffer: one register set plus a `pend_full` flag. `ready_out = ~pend_full`. A handshake loads the buffer and sets the flag.
- Shift buffer: holds the frame currently being transmitted.
- On every frame edge:
  - If `pend_full` is set: copy pending into shift and clear `pend_full`.
  - If `pend_full` is clear: pulse `underrun_out` and load the shift buffer with zeros.
  - In all cases: pulse `frame_start_out`, set bit index b=0, enter SHIFT.
- States:
  - IDLE: `sd_out`=0, `sd_oe_out`=0.
  - SHIFT: on each sck fall, drive bit b, then increment b.
    - slot = b/32, pos = b%32.
    - `sd_out` = shift[slot][SAMPLE_W-1-pos] if pos < SAMPLE_W, else 0.
    - `sd_oe_out`=1.
  - When an sck fall occurs with b == SLOTS*32, go to IDLE and drive `sd_out`=0, `sd_oe_out`=0.
- Bit counter width is $clog2(SLOTS*32)+1.
- Frame edge while in SHIFT:
  - If b < SLOTS*32 (not all bits driven): pulse `resync_out`, then apply normal frame-edge handling (restart at b=0 with the new frame).
  - If b == SLOTS*32: normal back-to-back frame, no resync.
- Handshake and frame edge in the same cycle with `pend_full`=0: the underrun is taken, zeros are sent, and the accepted data stays pending for the next frame.
- Reset mid-frame: return to IDLE, clear `pend_full` and the shift buffer, and zero all outputs on the next cycle. The next frame edge follows normal handling.

## Timing
- Reset values: `sd_out`=0, `sd_oe_out`=0, `frame_start_out`=0, `underrun_out`=0, `resync_out`=0, `ready_out`=1.
- `sd_out` and `sd_oe_out` are registered. They change 3 `clk_in` cycles after a raw `sck_in` transition (2 synchronizer cycles + 1 edge register).
- Data is therefore stable well before the next sck rise, which is where the receiver samples.
- Pulse outputs assert in the same cycle as the shift-buffer load, i.e. 3 cycles after the raw sck rise.
- Requirement: each sck half period ≥ 8 `clk_in` cycles. The current top level uses 25.
- `ready_out` deasserts the cycle after a handshake. It reasserts the cycle after the frame edge that drains the pending buffer.

## Configuration
- `TDM_TX_HOLD_LAST_EN`:
  - Defined: an underrun leaves the shift buffer unchanged, so the previous frame's samples are retransmitted. `underrun_out` still pulses.
  - Undefined: an underrun transmits zeros.
  - After reset, the held frame is all zeros in both cases.

## Test plan
- SLOTS=2, load {0xABCDEF, 0x123456}, one ws pulse with 64-cycle frames -> `tdm_receive` reports slot0=0xABCDEF, slot1=0x123456; `frame_start_out` pulses once; bits 24-31 of each slot are 0.
- No load before the frame edge, macro undefined -> `underrun_out` pulses; both slots received as 0x000000.
- Macro defined, load 0x00F00F once, then three frames with no load -> three underrun pulses; every frame carries 0x00F00F.
- `valid_in` held high with two distinct sample sets -> first accepted immediately; `ready_out`=0 until the next frame edge; second set is transmitted in the frame after the first.
- ws pulse after 40 bits -> `resync_out` pulses; slot 0 MSB is driven on the next sck fall; no bits of the old frame follow.
- Assert `rst_in` at bit 30 -> next cycle `sd_out`=0, `sd_oe_out`=0, `ready_out`=1; next frame sends zeros with an underrun pulse.
